// File: rtl/or1200_dslot_pkg.sv
// Shared definitions for the delay-slot tracker.
//  - dslot_state_e : 2-bit FSM state encoding
//  - OR1200 branch-op encodings (mirrors the core's branch-op defines)
//  - is_branch()   : helper that qualifies a branch op with the ID bubble flag
package or1200_dslot_pkg;

  localparam int OR1200_BRANCHOP_WIDTH = 3;

  localparam logic [OR1200_BRANCHOP_WIDTH-1:0] OR1200_BRANCHOP_NOP = 3'd0;
  localparam logic [OR1200_BRANCHOP_WIDTH-1:0] OR1200_BRANCHOP_J   = 3'd1;
  localparam logic [OR1200_BRANCHOP_WIDTH-1:0] OR1200_BRANCHOP_JR  = 3'd2;
  localparam logic [OR1200_BRANCHOP_WIDTH-1:0] OR1200_BRANCHOP_BAL = 3'd3;
  localparam logic [OR1200_BRANCHOP_WIDTH-1:0] OR1200_BRANCHOP_BF  = 3'd4;
  localparam logic [OR1200_BRANCHOP_WIDTH-1:0] OR1200_BRANCHOP_BNF = 3'd5;
  localparam logic [OR1200_BRANCHOP_WIDTH-1:0] OR1200_BRANCHOP_RFE = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BR_DSI = 2'd1,
    ST_BR_NOP = 2'd2,
    ST_DSLOT  = 2'd3
  } dslot_state_e;

  // A real branch sits in ID only when the op is non-NOP and ID is not a bubble.
  function automatic logic is_branch(input logic [OR1200_BRANCHOP_WIDTH-1:0] op,
                                     input logic id_void);
    return (op != OR1200_BRANCHOP_NOP) && !id_void;
  endfunction

endpackage

// File: rtl/or1200_dslot_tracker.sv
// Delay-slot tracker: follows a branch from ID into EX and reports whether its
// delay slot is a valid instruction (dsi) or still a bubble (nop), then marks
// the slot instruction itself while it is in EX.
// Ports:
//  clk, rst (async, active low)
//  ex_freeze        EX stalled, everything holds
//  ex_flushpipe     return to idle; overrides freeze; pc/err/count kept
//  id_branch_op     branch op of ID instruction
//  id_void/if_void  bubble flags for ID and IF
//  id_pc            PC of ID instruction
//  ex_delayslot_dsi / ex_delayslot_nop / ex_in_dslot  registered state decodes
//  dslot_pc         PC captured when the slot instruction moves into EX
//  dslot_err        sticky: a branch occupied a delay slot
//  br_cnt           saturating count of completed branch+slot pairs
module or1200_dslot_tracker
  import or1200_dslot_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ex_freeze,
  input  logic                             ex_flushpipe,
  input  logic [OR1200_BRANCHOP_WIDTH-1:0] id_branch_op,
  input  logic                             id_void,
  input  logic                             if_void,
  input  logic [31:0]                      id_pc,
  output logic                             ex_delayslot_dsi,
  output logic                             ex_delayslot_nop,
  output logic                             ex_in_dslot,
  output logic [31:0]                      dslot_pc,
  output logic                             dslot_err,
  output logic [CNT_W-1:0]                 br_cnt
);

  dslot_state_e state, nxt;
  logic         br;
  logic         enter_slot;

  always_comb begin
    br         = is_branch(id_branch_op, id_void);
    nxt        = ST_IDLE;
    enter_slot = 1'b0;
    case (state)
      // DSLOT behaves like IDLE so back-to-back branch pairs chain directly.
      ST_IDLE, ST_DSLOT: begin
        if (br) nxt = if_void ? ST_BR_NOP : ST_BR_DSI;
      end
      ST_BR_DSI: begin
        nxt        = ST_DSLOT;
        enter_slot = 1'b1;
      end
      // Wait as long as needed for the slot instruction to show up in ID.
      ST_BR_NOP: begin
        if (id_void) nxt = ST_BR_NOP;
        else begin
          nxt        = ST_DSLOT;
          enter_slot = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      ex_delayslot_dsi <= 1'b0;
      ex_delayslot_nop <= 1'b0;
      ex_in_dslot      <= 1'b0;
      dslot_pc         <= '0;
      dslot_err        <= 1'b0;
      br_cnt           <= '0;
    end else if (ex_flushpipe) begin
      state            <= ST_IDLE;
      ex_delayslot_dsi <= 1'b0;
      ex_delayslot_nop <= 1'b0;
      ex_in_dslot      <= 1'b0;
    end else if (!ex_freeze) begin
      state            <= nxt;
      // Outputs are flops decoded from the next state so they line up with state.
      ex_delayslot_dsi <= (nxt == ST_BR_DSI);
      ex_delayslot_nop <= (nxt == ST_BR_NOP);
      ex_in_dslot      <= (nxt == ST_DSLOT);
      if (enter_slot) begin
        dslot_pc <= id_pc;
        if (br_cnt != {CNT_W{1'b1}}) br_cnt <= br_cnt + CNT_W'(1);
        // The instruction now entering the slot is itself a branch.
        if (id_branch_op != OR1200_BRANCHOP_NOP) dslot_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_or1200_dslot_tracker.sv
module tb_or1200_dslot_tracker;
  import or1200_dslot_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0, flush = 1'b0;
  logic [OR1200_BRANCHOP_WIDTH-1:0] op = OR1200_BRANCHOP_NOP;
  logic id_void = 1'b0, if_void = 1'b0;
  logic [31:0] id_pc = '0;

  logic dsi16, nop16, slot16, err16;
  logic [31:0] pc16;
  logic [15:0] cnt16;
  logic dsi4, nop4, slot4, err4;
  logic [31:0] pc4;
  logic [3:0] cnt4;

  int checks = 0;
  int failures = 0;

  // Reference model: tracks "a branch is waiting on its slot" (with / without a
  // known-valid slot) and "the slot is in EX", and an unbounded pair count.
  bit m_dsi, m_nop, m_slot, m_err;
  logic [31:0] m_pc;
  int m_pairs;

  always #5 clk = ~clk;

  or1200_dslot_tracker #(.CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .ex_freeze(freeze), .ex_flushpipe(flush),
    .id_branch_op(op), .id_void(id_void), .if_void(if_void), .id_pc(id_pc),
    .ex_delayslot_dsi(dsi16), .ex_delayslot_nop(nop16), .ex_in_dslot(slot16),
    .dslot_pc(pc16), .dslot_err(err16), .br_cnt(cnt16));

  or1200_dslot_tracker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ex_freeze(freeze), .ex_flushpipe(flush),
    .id_branch_op(op), .id_void(id_void), .if_void(if_void), .id_pc(id_pc),
    .ex_delayslot_dsi(dsi4), .ex_delayslot_nop(nop4), .ex_in_dslot(slot4),
    .dslot_pc(pc4), .dslot_err(err4), .br_cnt(cnt4));

  assert property (@(posedge clk) disable iff (!rst)
    (dsi16 && !freeze) |=> (!dsi16 && !nop16));

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_dsi = 0; m_nop = 0; m_slot = 0; m_err = 0; m_pc = '0; m_pairs = 0;
  endtask

  task automatic model_edge();
    bit br, slot_now;
    br = (op != OR1200_BRANCHOP_NOP) && !id_void;
    if (flush) begin
      m_dsi = 0; m_nop = 0; m_slot = 0;
    end else if (!freeze) begin
      // The waiting branch's slot moves into EX when it is known valid.
      slot_now = m_dsi || (m_nop && !id_void);
      if (slot_now) begin
        m_pc = id_pc;
        m_pairs++;
        if (op != OR1200_BRANCHOP_NOP) m_err = 1;
        m_dsi = 0; m_nop = 0; m_slot = 1;
      end else if (!m_nop) begin
        m_slot = 0;
        m_dsi = br && !if_void;
        m_nop = br && if_void;
      end
    end
  endtask

  task automatic idle_inputs();
    op = OR1200_BRANCHOP_NOP; id_void = 0; if_void = 0; freeze = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({dsi16, nop16, slot16, err16, pc16, cnt16} !== '0) begin
      failures++; $display("FAIL reset_state: got %0h expected 0", {dsi16, nop16, slot16, err16, pc16, cnt16});
    end
    op = OR1200_BRANCHOP_J; id_pc = 32'h100; step();
    checks++;
    if (dsi16 !== 1'b1) begin failures++; $display("FAIL reset_pre_dsi: got %0b expected 1", dsi16); end
    #2 rst = 0; model_reset();
    #1;
    checks++;
    if ({dsi16, nop16, slot16, err16, pc16, cnt16} !== '0) begin
      failures++; $display("FAIL reset_async: got %0h expected 0", {dsi16, nop16, slot16, err16, pc16, cnt16});
    end
    idle_inputs();
    @(posedge clk); #1 rst = 1;
    step();
    checks++;
    if ({dsi16, nop16, slot16, cnt16} !== '0) begin
      failures++; $display("FAIL reset_release: got %0h expected 0", {dsi16, nop16, slot16, cnt16});
    end
  endtask

  task automatic test_branch_dsi();
    apply_reset();
    op = OR1200_BRANCHOP_J; id_pc = 32'h100; step();
    checks++;
    if ({dsi16, nop16, slot16} !== 3'b100) begin
      failures++; $display("FAIL dsi_branch: got %03b expected 100", {dsi16, nop16, slot16});
    end
    op = OR1200_BRANCHOP_NOP; id_pc = 32'h104; step();
    checks++;
    if ({dsi16, nop16, slot16} !== 3'b001 || pc16 !== 32'h104 || cnt16 !== 16'd1) begin
      failures++; $display("FAIL dsi_slot: got %03b pc=%0h cnt=%0d expected 001 pc=104 cnt=1",
                           {dsi16, nop16, slot16}, pc16, cnt16);
    end
  endtask

  task automatic test_branch_nop();
    apply_reset();
    op = OR1200_BRANCHOP_BF; if_void = 1; id_pc = 32'h200; step();
    checks++;
    if ({dsi16, nop16} !== 2'b01) begin failures++; $display("FAIL nop_branch: got %02b expected 01", {dsi16, nop16}); end
    op = OR1200_BRANCHOP_NOP; id_void = 1; if_void = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dsi16, nop16, slot16} !== 3'b010) begin
        failures++; $display("FAIL nop_wait%0d: got %03b expected 010", i, {dsi16, nop16, slot16});
      end
    end
    id_void = 0; id_pc = 32'h204; step();
    checks++;
    if ({nop16, slot16} !== 2'b01 || pc16 !== 32'h204 || cnt16 !== 16'd1) begin
      failures++; $display("FAIL nop_slot: got nop/slot=%02b pc=%0h cnt=%0d expected 01 pc=204 cnt=1",
                           {nop16, slot16}, pc16, cnt16);
    end
  endtask

  task automatic test_freeze_flush();
    apply_reset();
    op = OR1200_BRANCHOP_J; id_pc = 32'h10; step();
    op = OR1200_BRANCHOP_NOP; id_pc = 32'h14; step();
    op = OR1200_BRANCHOP_JR; id_pc = 32'h40; step();
    op = OR1200_BRANCHOP_NOP; id_pc = 32'h44; freeze = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({dsi16, slot16} !== 2'b10) begin
        failures++; $display("FAIL freeze_hold%0d: got dsi/slot=%02b expected 10", i, {dsi16, slot16});
      end
    end
    flush = 1; step();
    checks++;
    if ({dsi16, nop16, slot16} !== 3'b000 || pc16 !== 32'h14 || cnt16 !== 16'd1) begin
      failures++; $display("FAIL flush_over_freeze: got %03b pc=%0h cnt=%0d expected 000 pc=14 cnt=1",
                           {dsi16, nop16, slot16}, pc16, cnt16);
    end
    idle_inputs(); step();
    checks++;
    if ({dsi16, nop16, slot16} !== 3'b000) begin
      failures++; $display("FAIL flush_idle: got %03b expected 000", {dsi16, nop16, slot16});
    end
  endtask

  task automatic test_branch_in_slot();
    apply_reset();
    op = OR1200_BRANCHOP_J; step();
    op = OR1200_BRANCHOP_BF; id_pc = 32'h300; step();
    checks++;
    if (err16 !== 1'b1 || slot16 !== 1'b1) begin
      failures++; $display("FAIL slot_err_set: got err=%0b slot=%0b expected 1 1", err16, slot16);
    end
    op = OR1200_BRANCHOP_NOP; step();
    op = OR1200_BRANCHOP_J; step();
    op = OR1200_BRANCHOP_NOP; step();
    checks++;
    if (err16 !== 1'b1 || cnt16 !== 16'd2) begin
      failures++; $display("FAIL slot_err_sticky: got err=%0b cnt=%0d expected 1 2", err16, cnt16);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    op = OR1200_BRANCHOP_J; step();
    op = OR1200_BRANCHOP_NOP; step();
    op = OR1200_BRANCHOP_BAL; step();
    checks++;
    if ({dsi16, slot16} !== 2'b10) begin failures++; $display("FAIL b2b_second: got %02b expected 10", {dsi16, slot16}); end
    op = OR1200_BRANCHOP_NOP; id_pc = 32'h88; step();
    checks++;
    if (slot16 !== 1'b1 || cnt16 !== 16'd2 || err16 !== 1'b0 || pc16 !== 32'h88) begin
      failures++; $display("FAIL b2b_pair: got slot=%0b cnt=%0d err=%0b pc=%0h expected 1 2 0 88",
                           slot16, cnt16, err16, pc16);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      op = OR1200_BRANCHOP_J; step();
      op = OR1200_BRANCHOP_NOP; step();
      if (i == 15) begin
        checks++;
        if (cnt4 !== 4'd15) begin failures++; $display("FAIL sat_at15: got %0d expected 15", cnt4); end
      end
    end
    checks++;
    if (cnt4 !== 4'd15 || cnt16 !== 16'd17) begin
      failures++; $display("FAIL sat_17: got cnt4=%0d cnt16=%0d expected 15 17", cnt4, cnt16);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      op      = ($urandom_range(0, 9) < 4) ? OR1200_BRANCHOP_WIDTH'($urandom_range(1, 6)) : OR1200_BRANCHOP_NOP;
      id_void = ($urandom_range(0, 3) == 0);
      if_void = ($urandom_range(0, 2) == 0);
      freeze  = ($urandom_range(0, 9) == 0);
      flush   = ($urandom_range(0, 24) == 0);
      id_pc   = $urandom;
      step();
      checks++;
      if ({dsi16, nop16, slot16, err16} !== {m_dsi, m_nop, m_slot, m_err} ||
          {dsi4, nop4, slot4, err4} !== {m_dsi, m_nop, m_slot, m_err}) begin
        failures++; $display("FAIL rand_flags cyc%0d: got %04b/%04b expected %04b", i,
                             {dsi16, nop16, slot16, err16}, {dsi4, nop4, slot4, err4}, {m_dsi, m_nop, m_slot, m_err});
      end
      checks++;
      if (pc16 !== m_pc || pc4 !== m_pc) begin
        failures++; $display("FAIL rand_pc cyc%0d: got %0h/%0h expected %0h", i, pc16, pc4, m_pc);
      end
      checks++;
      if (int'(cnt16) !== sat(m_pairs, 16) || int'(cnt4) !== sat(m_pairs, 4)) begin
        failures++; $display("FAIL rand_cnt cyc%0d: got %0d/%0d expected %0d/%0d", i,
                             cnt16, cnt4, sat(m_pairs, 16), sat(m_pairs, 4));
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_branch_dsi();
    test_branch_nop();
    test_freeze_flush();
    test_branch_in_slot();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
